servant_spi_mem_ctrl: RTL and testbench

Sits between the SERV core's instruction and data Wishbone buses and the single Wishbone-to-SPI RAM master bridge. It arbitrates the two requesters onto the one bridge port. For each data write it inserts the WRITE ENABLE transaction first, then optionally polls the device status register until the write-in-progress bit clears. It also guarantees that the bridge sees cyc low for at least one cycle between transactions.

---
 rtl/servant_spi_pkg.sv | 20 ++
 rtl/servant_spi_rr_arb.sv | 36 +++
 rtl/servant_spi_mem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_servant_spi_mem_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servant_spi_pkg.sv
// Shared constants for the SERV SPI memory path: controller FSM encoding,
// status-register fields and the SPI command bytes used by the bridge.
package servant_spi_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_I_RD   = 3'd1;
  localparam logic [2:0] ST_D_RD   = 3'd2;
  localparam logic [2:0] ST_D_WREN = 3'd3;
  localparam logic [2:0] ST_D_WR   = 3'd4;
  localparam logic [2:0] ST_D_POLL = 3'd5;
  localparam logic [2:0] ST_GAP    = 3'd6;

  localparam int STATUS_WIP_BIT = 0;

  localparam logic [7:0] CMD_PAGE_PROGRAM = 8'h02;
  localparam logic [7:0] CMD_READ         = 8'h03;
  localparam logic [7:0] CMD_READ_STATUS  = 8'h05;
  localparam logic [7:0] CMD_WRITE_ENABLE = 8'h06;

endpackage

// File: rtl/servant_spi_rr_arb.sv
// Two-requester round-robin arbiter. Grant is only offered while unlocked;
// the "served last" pointer moves on each grant.
module servant_spi_rr_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] grant
);

  // 0: instruction (req[0]) was served last, 1: data (req[1]) was served last
  logic last_reg;

  always_comb begin
    grant = 2'b00;
    if (!lock) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_reg ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_reg <= 1'b0;
    end else if (grant[1]) begin
      last_reg <= 1'b1;
    end else if (grant[0]) begin
      last_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/servant_spi_mem_ctrl.sv
// Arbitrates SERV instruction and data Wishbone buses onto one SPI bridge port,
// wrapping data writes with WRITE ENABLE and optional status polling.
module servant_spi_mem_ctrl
  import servant_spi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 24,
  parameter int POLL_WIP      = 1,
  parameter int WIP_BIT       = STATUS_WIP_BIT,
  parameter int POLL_LIMIT    = 1023
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-3:0] i_adr,
  input  logic                     i_cyc,
  output logic [31:0]              i_rdt,
  output logic                     i_ack,
  input  logic [ADDRESS_WIDTH-3:0] d_adr,
  input  logic [31:0]              d_dat,
  input  logic [3:0]               d_sel,
  input  logic                     d_we,
  input  logic                     d_cyc,
  output logic [31:0]              d_rdt,
  output logic                     d_ack,
  output logic [ADDRESS_WIDTH-3:0] mem_adr,
  output logic [31:0]              mem_dat,
  output logic [3:0]               mem_sel,
  output logic                     mem_we,
  output logic                     mem_cyc,
  input  logic [31:0]              mem_rdt,
  input  logic                     mem_ack,
  output logic                     poll_err
);

  localparam logic [15:0] POLL_LIMIT_W = 16'(POLL_LIMIT);

  logic [2:0]               state_reg;
  logic [2:0]               succ_reg;
  logic [2:0]               succ_next;
  logic                     owner_reg;
  logic                     abort_reg;
  logic [15:0]              poll_cnt_reg;
  logic [15:0]              poll_cnt_next;
  logic [ADDRESS_WIDTH-3:0] mem_adr_reg;
  logic [31:0]              mem_dat_reg;
  logic [3:0]               mem_sel_reg;
  logic                     mem_we_reg;
  logic                     mem_cyc_reg;
  logic [31:0]              i_rdt_reg;
  logic [31:0]              d_rdt_reg;
  logic                     i_ack_reg;
  logic                     d_ack_reg;
  logic                     poll_err_reg;
  logic [1:0]               req;
  logic [1:0]               grant;
  logic                     lock;
  logic                     owner_cyc;
  logic                     abort_now;
  logic                     wip;

  // A requester still holds cyc during its ack cycle, so mask it to avoid a re-grant.
  assign req           = {d_cyc & ~d_ack_reg, i_cyc & ~i_ack_reg};
  assign lock          = (state_reg != ST_IDLE);
  assign owner_cyc     = owner_reg ? d_cyc : i_cyc;
  assign abort_now     = abort_reg | ~owner_cyc;
  assign wip           = mem_rdt[WIP_BIT];
  assign poll_cnt_next = poll_cnt_reg + 16'd1;

  servant_spi_rr_arb u_arb (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .grant (grant)
  );

  // Where to go once the GAP after the current bridge transaction is over
  always_comb begin
    succ_next = ST_IDLE;
    if (!abort_now) begin
      case (state_reg)
        ST_D_WREN: succ_next = ST_D_WR;
        ST_D_WR:   if ((POLL_WIP != 0) && (mem_sel_reg != 4'h0)) succ_next = ST_D_POLL;
        ST_D_POLL: if (wip && (poll_cnt_next < POLL_LIMIT_W)) succ_next = ST_D_POLL;
        default:   succ_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      succ_reg     <= ST_IDLE;
      owner_reg    <= 1'b0;
      abort_reg    <= 1'b0;
      poll_cnt_reg <= 16'd0;
      mem_adr_reg  <= '0;
      mem_dat_reg  <= 32'd0;
      mem_sel_reg  <= 4'h0;
      mem_we_reg   <= 1'b0;
      mem_cyc_reg  <= 1'b0;
      i_rdt_reg    <= 32'd0;
      d_rdt_reg    <= 32'd0;
      i_ack_reg    <= 1'b0;
      d_ack_reg    <= 1'b0;
      poll_err_reg <= 1'b0;
    end else begin
      i_ack_reg <= 1'b0;
      d_ack_reg <= 1'b0;
      if (lock && !owner_cyc) abort_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          abort_reg <= 1'b0;
          if (grant[0]) begin
            owner_reg   <= 1'b0;
            state_reg   <= ST_I_RD;
            mem_adr_reg <= i_adr;
            mem_sel_reg <= 4'hF;
            mem_we_reg  <= 1'b0;
          end else if (grant[1]) begin
            owner_reg   <= 1'b1;
            mem_adr_reg <= d_adr;
            mem_dat_reg <= d_dat;
            if (!d_we) begin
              state_reg   <= ST_D_RD;
              mem_sel_reg <= d_sel;
              mem_we_reg  <= 1'b0;
            end else if (d_sel != 4'h0) begin
              state_reg   <= ST_D_WREN;
              mem_sel_reg <= 4'h0;
              mem_we_reg  <= 1'b1;
            end else begin
              // Raw write-enable pass-through: no WREN prefix, no polling
              state_reg    <= ST_D_WR;
              mem_sel_reg  <= 4'h0;
              mem_we_reg   <= 1'b1;
              poll_cnt_reg <= 16'd0;
            end
          end
        end

        ST_GAP: begin
          state_reg <= succ_reg;
          case (succ_reg)
            ST_IDLE: begin
              if (!abort_now) begin
                if (owner_reg) d_ack_reg <= 1'b1;
                else           i_ack_reg <= 1'b1;
              end
            end
            ST_D_WR: begin
              mem_adr_reg  <= d_adr;
              mem_dat_reg  <= d_dat;
              mem_sel_reg  <= d_sel;
              mem_we_reg   <= 1'b1;
              poll_cnt_reg <= 16'd0;
            end
            ST_D_POLL: begin
              mem_sel_reg <= 4'h0;
              mem_we_reg  <= 1'b0;
            end
            default: ;
          endcase
        end

        ST_I_RD, ST_D_RD, ST_D_WREN, ST_D_WR, ST_D_POLL: begin
          if (!mem_cyc_reg) begin
            mem_cyc_reg <= 1'b1;
          end else if (mem_ack) begin
            mem_cyc_reg <= 1'b0;
            state_reg   <= ST_GAP;
            succ_reg    <= succ_next;
            if (state_reg == ST_I_RD) i_rdt_reg <= mem_rdt;
            if (state_reg == ST_D_RD) d_rdt_reg <= mem_rdt;
            if (state_reg == ST_D_POLL) begin
              poll_cnt_reg <= poll_cnt_next;
              if (wip && (poll_cnt_next >= POLL_LIMIT_W)) poll_err_reg <= 1'b1;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem_adr  = mem_adr_reg;
  assign mem_dat  = mem_dat_reg;
  assign mem_sel  = mem_sel_reg;
  assign mem_we   = mem_we_reg;
  assign mem_cyc  = mem_cyc_reg;
  assign i_rdt    = i_rdt_reg;
  assign d_rdt    = d_rdt_reg;
  assign i_ack    = i_ack_reg;
  assign d_ack    = d_ack_reg;
  assign poll_err = poll_err_reg;

endmodule

// File: tb/tb_servant_spi_mem_ctrl.sv
// Directed bench for servant_spi_mem_ctrl with a small SPI-bridge model that
// acks after a fixed latency and replays scripted status bytes.
module tb_servant_spi_mem_ctrl;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [21:0] i_adr, d_adr, mem_adr;
  logic        i_cyc, d_cyc, d_we, i_ack, d_ack;
  logic [31:0] i_rdt, d_rdt, d_dat, mem_dat, mem_rdt;
  logic [3:0]  d_sel, mem_sel;
  logic        mem_we, mem_cyc, mem_ack, poll_err;

  always #5 clock = ~clock;

  servant_spi_mem_ctrl #(
    .ADDRESS_WIDTH (24),
    .POLL_WIP      (1),
    .WIP_BIT       (0),
    .POLL_LIMIT    (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .i_adr    (i_adr),
    .i_cyc    (i_cyc),
    .i_rdt    (i_rdt),
    .i_ack    (i_ack),
    .d_adr    (d_adr),
    .d_dat    (d_dat),
    .d_sel    (d_sel),
    .d_we     (d_we),
    .d_cyc    (d_cyc),
    .d_rdt    (d_rdt),
    .d_ack    (d_ack),
    .mem_adr  (mem_adr),
    .mem_dat  (mem_dat),
    .mem_sel  (mem_sel),
    .mem_we   (mem_we),
    .mem_cyc  (mem_cyc),
    .mem_rdt  (mem_rdt),
    .mem_ack  (mem_ack),
    .poll_err (poll_err)
  );

  typedef struct {
    logic [21:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          gap;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  txn_t        txns[$];
  logic [7:0]  status_q[$];
  logic [7:0]  status_stuck = 8'h00;
  txn_t        cur_txn;
  int          lat_cnt, low_cnt, cur_gap;
  int          mon_err = 0;
  int          i_ack_cnt = 0;
  int          d_ack_cnt = 0;

  function automatic logic [31:0] bridge_data(input logic [21:0] a);
    if (a == 22'h000100) return 32'hDEADBEEF;
    return {8'hC0, 2'b00, a};
  endfunction

  // Bridge model: ack LAT cycles after cyc rises, 1-cycle pulse
  initial begin
    mem_ack = 1'b0;
    mem_rdt = 32'd0;
    lat_cnt = 0;
    low_cnt = 0;
    cur_gap = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mem_ack = 1'b0;
        lat_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_cyc) begin
        if (lat_cnt == 0) begin
          cur_gap = low_cnt;
          low_cnt = 0;
        end
        lat_cnt++;
        if (lat_cnt == LAT) begin
          cur_txn.adr = mem_adr;
          cur_txn.dat = mem_dat;
          cur_txn.sel = mem_sel;
          cur_txn.we  = mem_we;
          cur_txn.gap = cur_gap;
          txns.push_back(cur_txn);
          if (mem_we) mem_rdt = 32'hFFFFFFFF;
          else if (mem_sel == 4'h0) begin
            if (status_q.size() > 0) mem_rdt = {24'h0, status_q.pop_front()};
            else                     mem_rdt = {24'h0, status_stuck};
          end else mem_rdt = bridge_data(mem_adr);
          mem_ack = 1'b1;
          lat_cnt = 0;
        end
      end else begin
        low_cnt++;
      end
    end
  end

  // Protocol monitor: exclusive single-cycle acks, stable bridge fields while cyc high
  initial begin
    logic        prev_i, prev_d, prev_cyc;
    logic [58:0] prev_fields;
    prev_i = 0; prev_d = 0; prev_cyc = 0; prev_fields = '0;
    forever begin
      @(negedge clock);
      if (i_ack && d_ack) mon_err++;
      if ((i_ack && prev_i) || (d_ack && prev_d)) mon_err++;
      if (mem_cyc && prev_cyc && ({mem_adr, mem_dat, mem_sel, mem_we} != prev_fields)) mon_err++;
      if (i_ack) i_ack_cnt++;
      if (d_ack) d_ack_cnt++;
      prev_i      = i_ack;
      prev_d      = d_ack;
      prev_cyc    = mem_cyc;
      prev_fields = {mem_adr, mem_dat, mem_sel, mem_we};
    end
  end

  task automatic run_iread(input logic [21:0] adr, output bit ok, output int cycles);
    i_adr = adr;
    i_cyc = 1'b1;
    ok = 0;
    cycles = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clock);
      cycles++;
      if (i_ack) ok = 1;
    end
    i_cyc = 1'b0;
  endtask

  task automatic run_dwrite(input logic [21:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output bit ok, output int base);
    base  = txns.size();
    d_adr = adr;
    d_dat = dat;
    d_sel = sel;
    d_we  = 1'b1;
    d_cyc = 1'b1;
    ok = 0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clock);
      if (d_ack) ok = 1;
    end
    d_cyc = 1'b0;
    d_we  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_cyc = 0; d_cyc = 0; d_we = 0; d_sel = 0; i_adr = 0; d_adr = 0; d_dat = 0;
    repeat (3) @(negedge clock);
    checks++;
    if ({mem_cyc, mem_we, mem_sel} !== 6'b0)
      begin errors++; $display("FAIL reset_mem_ctl cyc=%b we=%b sel=%h want 0", mem_cyc, mem_we, mem_sel); end
    checks++;
    if ({mem_adr, mem_dat} !== 54'b0)
      begin errors++; $display("FAIL reset_mem_bus adr=%h dat=%h want 0", mem_adr, mem_dat); end
    checks++;
    if ({i_ack, d_ack, poll_err} !== 3'b0)
      begin errors++; $display("FAIL reset_flags i_ack=%b d_ack=%b poll_err=%b want 0", i_ack, d_ack, poll_err); end
    checks++;
    if ({i_rdt, d_rdt} !== 64'b0)
      begin errors++; $display("FAIL reset_rdt i_rdt=%h d_rdt=%h want 0", i_rdt, d_rdt); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    $display("reset: outputs checked");
  endtask

  task automatic test_iread();
    bit ok; int cyc; int base; int d0;
    base = txns.size();
    d0 = d_ack_cnt;
    run_iread(22'h000100, ok, cyc);
    checks++;
    if (!ok) begin errors++; $display("FAIL iread_ack no i_ack within 60 cycles"); return; end
    checks++;
    if (cyc !== LAT + 3) begin errors++; $display("FAIL iread_latency got %0d want %0d", cyc, LAT + 3); end
    checks++;
    if (i_rdt !== 32'hDEADBEEF) begin errors++; $display("FAIL iread_data got %h want deadbeef", i_rdt); end
    checks++;
    if (txns.size() - base !== 1) begin errors++; $display("FAIL iread_txn_count got %0d want 1", txns.size() - base); end
    else begin
      checks++;
      if (txns[base].sel !== 4'hF || txns[base].we !== 1'b0 || txns[base].adr !== 22'h000100)
        begin errors++; $display("FAIL iread_txn sel=%h we=%b adr=%h want F 0 000100", txns[base].sel, txns[base].we, txns[base].adr); end
    end
    @(negedge clock); #1;
    checks++;
    if (i_ack !== 1'b0) begin errors++; $display("FAIL iread_ack_width i_ack=%b want 0", i_ack); end
    checks++;
    if (d_ack_cnt !== d0) begin errors++; $display("FAIL iread_no_dack d_acks=%0d want %0d", d_ack_cnt - d0, 0); end
    $display("iread: adr=000100 rdt=%h latency=%0d", i_rdt, cyc);
  endtask

  task automatic test_round_robin();
    bit ok; bit who; bit exp_d;
    i_adr = 22'h000010; d_adr = 22'h000020; d_we = 1'b0; d_sel = 4'hF;
    i_cyc = 1'b1; d_cyc = 1'b1;
    exp_d = 1'b1;
    for (int g = 0; g < 10; g++) begin
      ok = 0;
      for (int c = 0; c < 60 && !ok; c++) begin
        @(negedge clock);
        if (i_ack || d_ack) ok = 1;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_timeout grant %0d no ack", g); break; end
      who = d_ack;
      checks++;
      if (who !== exp_d) begin errors++; $display("FAIL rr_order grant %0d got data=%b want data=%b", g, who, exp_d); end
      checks++;
      if (who && d_rdt !== 32'hC0000020) begin errors++; $display("FAIL rr_drdt got %h want c0000020", d_rdt); end
      else if (!who && i_rdt !== 32'hC0000010) begin errors++; $display("FAIL rr_irdt got %h want c0000010", i_rdt); end
      $display("rr: grant %0d served %s", g, who ? "data" : "instr");
      if (who) d_cyc = 1'b0; else i_cyc = 1'b0;
      if (g == 9) begin
        i_cyc = 1'b0; d_cyc = 1'b0;
      end else begin
        @(negedge clock);
        if (who) d_cyc = 1'b1; else i_cyc = 1'b1;
      end
      exp_d = ~exp_d;
    end
    i_cyc = 1'b0; d_cyc = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_write_seq();
    bit ok; int base; int d0;
    logic [3:0] exp_sel [5];
    logic       exp_we  [5];
    exp_sel = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0};
    exp_we  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    status_q = '{8'h01, 8'h01, 8'h00};
    d0 = d_ack_cnt;
    run_dwrite(22'h000123, 32'h0000A55A, 4'b0011, ok, base);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_ack no d_ack within budget"); return; end
    checks++;
    if (txns.size() - base !== 5) begin errors++; $display("FAIL wr_txn_count got %0d want 5", txns.size() - base); end
    else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (txns[base+k].sel !== exp_sel[k] || txns[base+k].we !== exp_we[k] || txns[base+k].gap < 1)
          begin errors++; $display("FAIL wr_txn%0d sel=%h we=%b gap=%0d want sel=%h we=%b gap>=1", k, txns[base+k].sel, txns[base+k].we, txns[base+k].gap, exp_sel[k], exp_we[k]); end
      end
      checks++;
      if (txns[base].adr !== 22'h000123 || txns[base+1].adr !== 22'h000123 || txns[base+1].dat !== 32'h0000A55A)
        begin errors++; $display("FAIL wr_payload wren_adr=%h wr_adr=%h wr_dat=%h want 000123 000123 0000a55a", txns[base].adr, txns[base+1].adr, txns[base+1].dat); end
    end
    repeat (3) @(negedge clock); #1;
    checks++;
    if (d_ack_cnt - d0 !== 1) begin errors++; $display("FAIL wr_single_ack got %0d acks want 1", d_ack_cnt - d0); end
    checks++;
    if (d_rdt !== 32'hC0000020) begin errors++; $display("FAIL wr_drdt_held got %h want c0000020", d_rdt); end
    checks++;
    if (poll_err !== 1'b0) begin errors++; $display("FAIL wr_poll_err got %b want 0", poll_err); end
    $display("write: %0d bridge transactions, poll_err=%b", txns.size() - base, poll_err);
  endtask

  task automatic test_passthrough();
    bit ok; int base;
    run_dwrite(22'h000040, 32'h12345678, 4'h0, ok, base);
    checks++;
    if (!ok) begin errors++; $display("FAIL pt_ack no d_ack within budget"); return; end
    checks++;
    if (txns.size() - base !== 1) begin errors++; $display("FAIL pt_txn_count got %0d want 1", txns.size() - base); end
    else begin
      checks++;
      if (txns[base].sel !== 4'h0 || txns[base].we !== 1'b1)
        begin errors++; $display("FAIL pt_txn sel=%h we=%b want 0 1", txns[base].sel, txns[base].we); end
    end
    checks++;
    if (d_rdt !== 32'hC0000020) begin errors++; $display("FAIL pt_drdt_held got %h want c0000020", d_rdt); end
    $display("passthrough: %0d bridge transaction(s)", txns.size() - base);
  endtask

  task automatic test_poll_timeout();
    bit ok; int base; int cyc;
    status_q.delete();
    status_stuck = 8'h01;
    run_dwrite(22'h000200, 32'h00000077, 4'hF, ok, base);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_ack no d_ack within budget"); return; end
    checks++;
    if (txns.size() - base !== 6) begin errors++; $display("FAIL to_txn_count got %0d want 6 (2 + 4 polls)", txns.size() - base); end
    checks++;
    if (poll_err !== 1'b1) begin errors++; $display("FAIL to_poll_err got %b want 1", poll_err); end
    status_stuck = 8'h00;
    @(negedge clock);
    run_iread(22'h000055, ok, cyc);
    checks++;
    if (!ok || i_rdt !== 32'hC0000055) begin errors++; $display("FAIL to_followup_read ok=%b rdt=%h want 1 c0000055", ok, i_rdt); end
    checks++;
    if (poll_err !== 1'b1) begin errors++; $display("FAIL to_poll_err_sticky got %b want 1", poll_err); end
    $display("poll timeout: %0d bridge transactions, poll_err=%b", txns.size() - base, poll_err);
  endtask

  task automatic test_abort();
    bit seen; int base; int i0;
    base = txns.size();
    i0 = i_ack_cnt;
    i_adr = 22'h000077;
    i_cyc = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (mem_cyc) seen = 1;
    end
    i_cyc = 1'b0;
    repeat (15) @(negedge clock);
    #1;
    checks++;
    if (!seen || txns.size() - base !== 1) begin errors++; $display("FAIL abort_completes cyc_seen=%b txns=%0d want 1 1", seen, txns.size() - base); end
    checks++;
    if (i_ack_cnt !== i0) begin errors++; $display("FAIL abort_ack_suppressed got %0d acks want 0", i_ack_cnt - i0); end
    $display("abort: transaction completed, acks=%0d", i_ack_cnt - i0);
  endtask

  task automatic test_reset_mid_write();
    bit seen; bit ok; int cyc;
    status_stuck = 8'h01;
    d_adr = 22'h000300; d_dat = 32'hCAFEF00D; d_sel = 4'h3; d_we = 1'b1; d_cyc = 1'b1;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clock);
      if (mem_cyc && mem_we && mem_sel == 4'h3) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_reach never saw write phase"); end
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_cyc, d_ack, poll_err} !== 3'b0)
      begin errors++; $display("FAIL rst_mid_async cyc=%b d_ack=%b poll_err=%b want 0", mem_cyc, d_ack, poll_err); end
    d_cyc = 1'b0; d_we = 1'b0;
    status_stuck = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_iread(22'h000100, ok, cyc);
    checks++;
    if (!ok || i_rdt !== 32'hDEADBEEF || cyc !== LAT + 3)
      begin errors++; $display("FAIL rst_mid_recover ok=%b rdt=%h lat=%0d want 1 deadbeef %0d", ok, i_rdt, cyc, LAT + 3); end
    $display("reset mid-write: recovered read rdt=%h", i_rdt);
  endtask

  initial begin
    test_reset();
    test_iread();
    test_round_robin();
    test_write_seq();
    test_passthrough();
    test_poll_timeout();
    test_abort();
    test_reset_mid_write();
    repeat (3) @(negedge clock);
    checks++;
    if (mon_err !== 0) begin errors++; $display("FAIL protocol_monitor violations=%0d want 0", mon_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
